// File: rtl/arb_pkg.sv
// Shared definitions for the 8-requester arbiter: state encoding, sizes and
// the one-hot to binary index helper.
package arb_pkg;

  localparam int NUM_REQ = 8;
  localparam int ID_W    = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  function automatic logic [ID_W-1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
    logic [ID_W-1:0] idx;
    idx = {ID_W{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (oh[i]) begin
        idx = idx | ID_W'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/arb_priority_pick.sv
// Combinational highest-priority one-hot picker (bit 7 highest).
// With RR_EN defined the input is rotated so bit (rot-1) wins first and rot is lowest.
module arb_priority_pick
  import arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_vec,
`ifdef RR_EN
  input  logic [ID_W-1:0]    rot,
`endif
  output logic [NUM_REQ-1:0] pick_oh,
  output logic               none
);

  logic [NUM_REQ-1:0] rot_req_s;
  logic [NUM_REQ-1:0] rot_pick_s;

`ifdef RR_EN
  logic [2*NUM_REQ-1:0] dbl_req_s;
  logic [2*NUM_REQ-1:0] dbl_pick_s;

  // Rotate right by rot into priority space, rotate the winner back left.
  always_comb begin
    dbl_req_s  = {req_vec, req_vec} >> rot;
    rot_req_s  = dbl_req_s[NUM_REQ-1:0];
    dbl_pick_s = {rot_pick_s, rot_pick_s} << rot;
    pick_oh    = dbl_pick_s[2*NUM_REQ-1:NUM_REQ];
  end
`else
  // Fixed priority: no rotation.
  always_comb begin
    rot_req_s = req_vec;
    pick_oh   = rot_pick_s;
  end
`endif

  // Upward scan so the highest set bit overwrites any lower one.
  always_comb begin
    rot_pick_s = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (rot_req_s[i]) begin
        rot_pick_s    = {NUM_REQ{1'b0}};
        rot_pick_s[i] = 1'b1;
      end else begin
        rot_pick_s = rot_pick_s;
      end
    end
  end

  assign none = (req_vec == {NUM_REQ{1'b0}});

endmodule

// File: rtl/req_arbiter_8ch.sv
// 8-requester arbiter with registered grant, bounded hold time and a
// one-cycle gap between owners. Define RR_EN for round-robin priority.
module req_arbiter_8ch
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req,
  output logic [NUM_REQ-1:0]  grant,
  output logic [ID_W-1:0]     grant_id,
  output logic                grant_valid,
  output logic                expire,
  output logic                idle
);

  localparam int CNT_W = 8;
  localparam bit HOLD_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_EN ? MAX_HOLD - 1 : 0);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  arb_state_e         state_r, state_s;
  logic [NUM_REQ-1:0] grant_r, grant_s;
  logic [ID_W-1:0]    grant_id_r, grant_id_s;
  logic               grant_valid_r, grant_valid_s;
  logic               expire_r, expire_s;
  logic [CNT_W-1:0]   hold_cnt_r, hold_cnt_s;
  logic [NUM_REQ-1:0] mask_r, mask_s;
  logic [NUM_REQ-1:0] masked_s, cand_s, pick_oh_s;
  logic               pick_none_s;
  logic [ID_W-1:0]    pick_id_s;
  logic               owner_req_s;

  // The expiry mask only steers the pick while some unmasked requester exists.
  assign masked_s    = req & ~mask_r;
  assign cand_s      = (masked_s != {NUM_REQ{1'b0}}) ? masked_s : req;
  assign pick_id_s   = onehot_to_idx(pick_oh_s);
  assign owner_req_s = req[grant_id_r];

`ifdef RR_EN
  logic [ID_W-1:0] last_id_r, last_id_s;

  arb_priority_pick u_pick (
    .req_vec (cand_s),
    .rot     (last_id_r),
    .pick_oh (pick_oh_s),
    .none    (pick_none_s)
  );
`else
  arb_priority_pick u_pick (
    .req_vec (cand_s),
    .pick_oh (pick_oh_s),
    .none    (pick_none_s)
  );
`endif

  // Next-state and next-output computation.
  always_comb begin
    state_s       = state_r;
    grant_s       = grant_r;
    grant_id_s    = grant_id_r;
    grant_valid_s = grant_valid_r;
    expire_s      = 1'b0;
    hold_cnt_s    = hold_cnt_r;
    mask_s        = mask_r;
`ifdef RR_EN
    last_id_s     = last_id_r;
`endif
    case (state_r)
      IDLE, GAP: begin
        mask_s = {NUM_REQ{1'b0}};
        if (!pick_none_s) begin
          state_s       = GRANT;
          grant_s       = pick_oh_s;
          grant_id_s    = pick_id_s;
          grant_valid_s = 1'b1;
          hold_cnt_s    = {CNT_W{1'b0}};
`ifdef RR_EN
          last_id_s     = pick_id_s;
`endif
        end else begin
          state_s       = IDLE;
          grant_s       = {NUM_REQ{1'b0}};
          grant_id_s    = {ID_W{1'b0}};
          grant_valid_s = 1'b0;
        end
      end
      GRANT: begin
        if (!owner_req_s) begin
          state_s       = GAP;
          grant_s       = {NUM_REQ{1'b0}};
          grant_id_s    = {ID_W{1'b0}};
          grant_valid_s = 1'b0;
        end else if (HOLD_EN && (hold_cnt_r == HOLD_LAST)) begin
          state_s       = GAP;
          grant_s       = {NUM_REQ{1'b0}};
          grant_id_s    = {ID_W{1'b0}};
          grant_valid_s = 1'b0;
          expire_s      = 1'b1;
          mask_s        = grant_r;
        end else begin
          hold_cnt_s = (hold_cnt_r == CNT_MAX) ? hold_cnt_r : hold_cnt_r + CNT_W'(1);
        end
      end
      default: begin
        state_s       = IDLE;
        grant_s       = {NUM_REQ{1'b0}};
        grant_id_s    = {ID_W{1'b0}};
        grant_valid_s = 1'b0;
        hold_cnt_s    = {CNT_W{1'b0}};
        mask_s        = {NUM_REQ{1'b0}};
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= IDLE;
      grant_r       <= {NUM_REQ{1'b0}};
      grant_id_r    <= {ID_W{1'b0}};
      grant_valid_r <= 1'b0;
      expire_r      <= 1'b0;
      hold_cnt_r    <= {CNT_W{1'b0}};
      mask_r        <= {NUM_REQ{1'b0}};
`ifdef RR_EN
      last_id_r     <= {ID_W{1'b0}};
`endif
    end else begin
      state_r       <= state_s;
      grant_r       <= grant_s;
      grant_id_r    <= grant_id_s;
      grant_valid_r <= grant_valid_s;
      expire_r      <= expire_s;
      hold_cnt_r    <= hold_cnt_s;
      mask_r        <= mask_s;
`ifdef RR_EN
      last_id_r     <= last_id_s;
`endif
    end
  end

  assign grant       = grant_r;
  assign grant_id    = grant_id_r;
  assign grant_valid = grant_valid_r;
  assign expire      = expire_r;
  assign idle        = (req == {NUM_REQ{1'b0}}) && !grant_valid_r;

endmodule

// File: tb/tb_req_arbiter_8ch.sv
// Scoreboard bench for req_arbiter_8ch with MAX_HOLD=4: a driver pushes the
// expected post-edge outputs per cycle, a monitor pops and compares them.
module tb_req_arbiter_8ch;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] grant;
  logic [2:0] grant_id;
  logic       grant_valid;
  logic       expire;
  logic       idle;

  req_arbiter_8ch #(.MAX_HOLD(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .grant       (grant),
    .grant_id    (grant_id),
    .grant_valid (grant_valid),
    .expire      (expire),
    .idle        (idle)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] grant;
    logic [2:0] id;
    logic       expire;
    logic       idle;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Apply inputs on the falling edge and queue the outputs due after the next rising edge.
  task automatic step(input logic r, input logic [7:0] rq, input logic [7:0] g,
                      input logic [2:0] id, input logic ex);
    exp_t e;
    @(negedge clk);
    rst = r;
    req = rq;
    e.grant  = g;
    e.id     = id;
    e.expire = ex;
    e.idle   = (rq == 8'h00) && (g == 8'h00);
    exp_q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      check("grant",       grant,                 mon_e.grant);
      check("grant_id",    {5'd0, grant_id},      {5'd0, mon_e.id});
      check("grant_valid", {7'd0, grant_valid},   {7'd0, (mon_e.grant != 8'h00)});
      check("expire",      {7'd0, expire},        {7'd0, mon_e.expire});
      check("idle",        {7'd0, idle},          {7'd0, mon_e.idle});
    end
  end

  initial begin
    // reset state
    step(1'b1, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // basic pick, then release
    step(1'b0, 8'h05, 8'h04, 3'd2, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // expiry and masking with 0xC0 held
    repeat (4) step(1'b0, 8'hC0, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'hC0, 8'h00, 3'd0, 1'b1);
    repeat (4) step(1'b0, 8'hC0, 8'h40, 3'd6, 1'b0);
    step(1'b0, 8'hC0, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'hC0, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // early release, new request arbitrated during the gap
    step(1'b0, 8'h10, 8'h10, 3'd4, 1'b0);
    step(1'b0, 8'h10, 8'h10, 3'd4, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h01, 8'h01, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // lone requester is regranted after expiry
    repeat (4) step(1'b0, 8'h08, 8'h08, 3'd3, 1'b0);
    step(1'b0, 8'h08, 8'h00, 3'd0, 1'b1);
    repeat (4) step(1'b0, 8'h08, 8'h08, 3'd3, 1'b0);
    step(1'b0, 8'h08, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h08, 8'h08, 3'd3, 1'b0);
    // other requests ignored while held; owner release hands over after the gap
    step(1'b0, 8'hFF, 8'h08, 3'd3, 1'b0);
    step(1'b0, 8'hF7, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'hF7, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // reset mid-grant with all requests active
    step(1'b0, 8'h20, 8'h20, 3'd5, 1'b0);
    step(1'b1, 8'hFF, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'hFF, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    // two contenders alternate through expiry
    repeat (4) step(1'b0, 8'h81, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'h81, 8'h00, 3'd0, 1'b1);
    repeat (4) step(1'b0, 8'h81, 8'h01, 3'd0, 1'b0);
    step(1'b0, 8'h81, 8'h00, 3'd0, 1'b1);
    step(1'b0, 8'h81, 8'h80, 3'd7, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);
    step(1'b0, 8'h00, 8'h00, 3'd0, 1'b0);

    @(posedge clk);
    #2;
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
